bram_arbiter_wb32: RTL and testbench

Two-master Wishbone arbiter placed in front of the 32-bit byte-lane BRAM slave. Lets the CPU (master 0) and a second requester such as DMA or video fetch (master 1) share one single-port BRAM. Each accepted request becomes exactly one single-cycle strobe at the slave, and the slave acknowledge is returned only to the granted master. Arbitration is round-robin or fixed-priority, selected by parameter.

---
 rtl/bram_arbiter_wb32_pkg.sv | 14 +
 rtl/bram_arbiter_wb32_rr_arb2.sv | 59 +++++
 rtl/bram_arbiter_wb32.sv | 122 ++++++++++++
 tb/tb_bram_arbiter_wb32.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arbiter_wb32_pkg.sv
// Shared definitions for the two-master Wishbone BRAM arbiter:
// FSM state encoding and arbitration mode constants.
package bram_arbiter_wb32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/bram_arbiter_wb32_rr_arb2.sv
// Two-requester arbiter with one-hot grant. Round-robin mode alternates
// under contention using last_grant; fixed mode always favours requester 0.
module rr_arb2
    import bram_arbiter_wb32_pkg::*;
#(
    parameter int PRIORITY = PRIO_RR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Index of the most recently granted requester; 1 after reset so
    // requester 0 wins the first contended round.
    logic last_grant_reg;
    logic last_grant_next;

    // Grant selection, only active while enabled.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (PRIORITY == PRIO_FIXED) begin
                if (req[0]) begin
                    gnt = 2'b01;
                end else if (req[1]) begin
                    gnt = 2'b10;
                end
            end else begin
                if (req == 2'b11) begin
                    gnt = last_grant_reg ? 2'b01 : 2'b10;
                end else begin
                    gnt = req;
                end
            end
        end
    end

    // Remember who was granted last, updated on every grant.
    always_comb begin
        last_grant_next = last_grant_reg;
        if (gnt[1]) begin
            last_grant_next = 1'b1;
        end else if (gnt[0]) begin
            last_grant_next = 1'b0;
        end
    end

    // last_grant state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: rtl/bram_arbiter_wb32.sv
// Two-master Wishbone arbiter in front of a single-port 32-bit BRAM slave.
// Each accepted request produces one registered single-cycle slave strobe;
// the slave ack is routed back only to the granted master.
module bram_arbiter_wb32
    import bram_arbiter_wb32_pkg::*;
#(
    parameter int ADDRBITS = 11,
    parameter int PRIORITY = PRIO_RR
) (
    input  logic                I_wb_clk,
    input  logic                I_wb_rst_n,
    input  logic                I_m0_stb,
    input  logic                I_m1_stb,
    input  logic                I_m0_we,
    input  logic                I_m1_we,
    input  logic [ADDRBITS-1:0] I_m0_adr,
    input  logic [ADDRBITS-1:0] I_m1_adr,
    input  logic [31:0]         I_m0_dat,
    input  logic [31:0]         I_m1_dat,
    input  logic [3:0]          I_m0_sel,
    input  logic [3:0]          I_m1_sel,
    output logic [31:0]         O_m0_dat,
    output logic [31:0]         O_m1_dat,
    output logic                O_m0_ack,
    output logic                O_m1_ack,
    output logic                O_s_stb,
    output logic                O_s_we,
    output logic [ADDRBITS-1:0] O_s_adr,
    output logic [31:0]         O_s_dat,
    output logic [3:0]          O_s_sel,
    input  logic [31:0]         I_s_dat,
    input  logic                I_s_ack
);

    state_t                state_reg, state_next;
    logic [1:0]            grant_reg, grant_next;
    logic                  s_stb_reg, s_stb_next;
    logic                  s_we_reg, s_we_next;
    logic [ADDRBITS-1:0]   s_adr_reg, s_adr_next;
    logic [31:0]           s_dat_reg, s_dat_next;
    logic [3:0]            s_sel_reg, s_sel_next;
    logic [1:0]            m_stb;
    logic [1:0]            arb_gnt;
    logic [1:0]            m_ack;

    assign m_stb = {I_m1_stb, I_m0_stb};

    rr_arb2 #(
        .PRIORITY (PRIORITY)
    ) u_arb (
        .clk   (I_wb_clk),
        .rst_n (I_wb_rst_n),
        .en    (state_reg == IDLE),
        .req   (m_stb),
        .gnt   (arb_gnt)
    );

    // Next-state logic: latch the winner's request in IDLE, strobe for one
    // cycle in REQ, collect the ack in ACK.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        s_stb_next = 1'b0;
        s_we_next  = s_we_reg;
        s_adr_next = s_adr_reg;
        s_dat_next = s_dat_reg;
        s_sel_next = s_sel_reg;
        case (state_reg)
            IDLE: begin
                if (|arb_gnt) begin
                    grant_next = arb_gnt;
                    s_stb_next = 1'b1;
                    s_we_next  = arb_gnt[1] ? I_m1_we  : I_m0_we;
                    s_adr_next = arb_gnt[1] ? I_m1_adr : I_m0_adr;
                    s_dat_next = arb_gnt[1] ? I_m1_dat : I_m0_dat;
                    s_sel_next = arb_gnt[1] ? I_m1_sel : I_m0_sel;
                    state_next = REQ;
                end
            end
            REQ:     state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and slave-side registers; reset aborts any in-flight transfer.
    always_ff @(posedge I_wb_clk or negedge I_wb_rst_n) begin
        if (!I_wb_rst_n) begin
            state_reg <= IDLE;
            grant_reg <= 2'b00;
            s_stb_reg <= 1'b0;
            s_we_reg  <= 1'b0;
            s_adr_reg <= '0;
            s_dat_reg <= '0;
            s_sel_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            s_stb_reg <= s_stb_next;
            s_we_reg  <= s_we_next;
            s_adr_reg <= s_adr_next;
            s_dat_reg <= s_dat_next;
            s_sel_reg <= s_sel_next;
        end
    end

    // Ack goes only to the granted master, and only if it still requests.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
        assign m_ack[gi] = (state_reg == ACK) & grant_reg[gi] & I_s_ack & m_stb[gi];
    end

    assign O_m0_ack = m_ack[0];
    assign O_m1_ack = m_ack[1];
    assign O_m0_dat = I_s_dat;
    assign O_m1_dat = I_s_dat;
    assign O_s_stb  = s_stb_reg;
    assign O_s_we   = s_we_reg;
    assign O_s_adr  = s_adr_reg;
    assign O_s_dat  = s_dat_reg;
    assign O_s_sel  = s_sel_reg;

endmodule

// File: tb/tb_bram_arbiter_wb32.sv
// Directed bench for bram_arbiter_wb32: instance 0 is round-robin,
// instance 1 is fixed priority; each has its own byte-lane BRAM slave.
module tb_bram_arbiter_wb32;

    logic        clk;
    logic [1:0]  rst_n;
    logic [1:0]  stb [2];
    logic [1:0]  we  [2];
    logic [10:0] adr [2][2];
    logic [31:0] wdat [2][2];
    logic [3:0]  sel [2][2];

    logic [1:0]  m0_ack;
    logic [1:0]  m1_ack;
    logic [31:0] m0_rdat [2];
    logic [31:0] m1_rdat [2];
    logic [1:0]  s_stb;
    logic [1:0]  s_we;
    logic [10:0] s_adr [2];
    logic [31:0] s_wdat [2];
    logic [3:0]  s_sel [2];
    logic [31:0] s_rdat [2];
    logic [1:0]  s_ack;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [31:0] mem [0:2047];

        bram_arbiter_wb32 #(
            .ADDRBITS (11),
            .PRIORITY (gi)
        ) u_dut (
            .I_wb_clk   (clk),
            .I_wb_rst_n (rst_n[gi]),
            .I_m0_stb   (stb[gi][0]),
            .I_m1_stb   (stb[gi][1]),
            .I_m0_we    (we[gi][0]),
            .I_m1_we    (we[gi][1]),
            .I_m0_adr   (adr[gi][0]),
            .I_m1_adr   (adr[gi][1]),
            .I_m0_dat   (wdat[gi][0]),
            .I_m1_dat   (wdat[gi][1]),
            .I_m0_sel   (sel[gi][0]),
            .I_m1_sel   (sel[gi][1]),
            .O_m0_dat   (m0_rdat[gi]),
            .O_m1_dat   (m1_rdat[gi]),
            .O_m0_ack   (m0_ack[gi]),
            .O_m1_ack   (m1_ack[gi]),
            .O_s_stb    (s_stb[gi]),
            .O_s_we     (s_we[gi]),
            .O_s_adr    (s_adr[gi]),
            .O_s_dat    (s_wdat[gi]),
            .O_s_sel    (s_sel[gi]),
            .I_s_dat    (s_rdat[gi]),
            .I_s_ack    (s_ack[gi])
        );

        // BRAM slave: registered read data and ack, byte-lane writes.
        always @(posedge clk) begin
            s_ack[gi] <= s_stb[gi];
            if (s_stb[gi]) begin
                if (s_we[gi]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_sel[gi][b]) mem[s_adr[gi]][8*b +: 8] <= s_wdat[gi][8*b +: 8];
                    end
                end
                s_rdat[gi] <= mem[s_adr[gi]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer by master m on instance d, starting in IDLE.
    task automatic xfer(input int d, input int m, input logic w, input logic [10:0] a,
                        input logic [31:0] dt, input logic [3:0] s, input logic [31:0] exp_rd);
        logic ack_m, ack_o;
        logic [31:0] rd;
        we[d][m]   = w;
        adr[d][m]  = a;
        wdat[d][m] = dt;
        sel[d][m]  = s;
        stb[d][m]  = 1'b1;
        tick();
        chk("req_stb", s_stb[d], 1);
        chk("req_adr", s_adr[d], a);
        chk("req_we", s_we[d], w);
        chk("req_sel", s_sel[d], s);
        if (w) chk("req_dat", s_wdat[d], dt);
        chk("req_noack", m0_ack[d] | m1_ack[d], 0);
        tick();
        ack_m = (m == 0) ? m0_ack[d] : m1_ack[d];
        ack_o = (m == 0) ? m1_ack[d] : m0_ack[d];
        rd    = (m == 0) ? m0_rdat[d] : m1_rdat[d];
        chk("ack_stb", s_stb[d], 0);
        chk("ack_mine", ack_m, 1);
        chk("ack_other", ack_o, 0);
        if (!w) chk("rd_dat", rd, exp_rd);
        stb[d][m] = 1'b0;
        tick();
        $display("xfer inst=%0d m=%0d we=%0b adr=%h dat=%h sel=%b rd=%h", d, m, w, a, dt, s, rd);
    endtask

    initial begin
        rst_n = 2'b00;
        for (int d = 0; d < 2; d++) begin
            stb[d] = 2'b00;
            we[d]  = 2'b00;
            for (int m = 0; m < 2; m++) begin
                adr[d][m]  = '0;
                wdat[d][m] = '0;
                sel[d][m]  = '0;
            end
        end
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_stb", s_stb[d], 0);
            chk("rst_we", s_we[d], 0);
            chk("rst_adr", s_adr[d], 0);
            chk("rst_dat", s_wdat[d], 0);
            chk("rst_sel", s_sel[d], 0);
            chk("rst_ack", {m1_ack[d], m0_ack[d]}, 0);
        end
        $display("reset state checked");
        rst_n = 2'b11;
        tick();

        // Single read by m0 after preload, then byte-lane write by m1.
        xfer(0, 0, 1'b1, 11'h010, 32'hDEADBEEF, 4'hF, 32'h0);
        xfer(0, 0, 1'b0, 11'h010, 32'h0, 4'hF, 32'hDEADBEEF);
        xfer(0, 1, 1'b1, 11'h020, 32'hAAAAAAAA, 4'hF, 32'h0);
        xfer(0, 1, 1'b1, 11'h020, 32'h11223344, 4'b0101, 32'h0);
        xfer(0, 1, 1'b0, 11'h020, 32'h0, 4'hF, 32'hAA22AA44);

        // Round-robin contention from reset: m0, m1, m0, m1.
        rst_n[0] = 1'b0;
        we[0] = 2'b00;
        adr[0][0] = 11'h100;
        adr[0][1] = 11'h200;
        stb[0] = 2'b11;
        tick();
        rst_n[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_stb", s_stb[0], 1);
            chk("rr_adr", s_adr[0], (k % 2 == 1) ? 11'h200 : 11'h100);
            tick();
            chk("rr_m0ack", m0_ack[0], (k % 2 == 0) ? 1 : 0);
            chk("rr_m1ack", m1_ack[0], (k % 2 == 1) ? 1 : 0);
            $display("rr transfer %0d m0_ack=%0b m1_ack=%0b", k, m0_ack[0], m1_ack[0]);
            tick();
            chk("rr_idle_stb", s_stb[0], 0);
        end

        // Reset in REQ after an m0 grant; first contended grant afterwards is m0 again.
        tick();
        chk("mid_req_adr", s_adr[0], 11'h100);
        rst_n[0] = 1'b0;
        #1;
        chk("mid_rst_stb", s_stb[0], 0);
        chk("mid_rst_ack", {m1_ack[0], m0_ack[0]}, 0);
        tick();
        chk("mid_rst_ack2", {m1_ack[0], m0_ack[0]}, 0);
        chk("mid_rst_stb2", s_stb[0], 0);
        rst_n[0] = 1'b1;
        tick();
        chk("post_rst_adr", s_adr[0], 11'h100);
        tick();
        chk("post_rst_m0ack", m0_ack[0], 1);
        chk("post_rst_m1ack", m1_ack[0], 0);
        stb[0] = 2'b00;
        tick();
        $display("mid-transfer reset checked");

        // Fixed priority: m0 wins four times, m1 served once m0 lets go.
        we[1] = 2'b00;
        adr[1][0] = 11'h100;
        adr[1][1] = 11'h200;
        stb[1] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fx_adr", s_adr[1], 11'h100);
            tick();
            chk("fx_m0ack", m0_ack[1], 1);
            chk("fx_m1ack", m1_ack[1], 0);
            $display("fixed transfer %0d m0_ack=%0b m1_ack=%0b", k, m0_ack[1], m1_ack[1]);
            if (k == 3) stb[1][0] = 1'b0;
            tick();
        end
        tick();
        chk("fx_m1_adr", s_adr[1], 11'h200);
        chk("fx_m1_stb", s_stb[1], 1);
        tick();
        chk("fx_m1_ack", m1_ack[1], 1);
        chk("fx_m0_noack", m0_ack[1], 0);
        stb[1] = 2'b00;
        tick();

        // Abandoned write: m1 drops stb in ACK; write still lands, no ack.
        we[0][1]   = 1'b1;
        adr[0][1]  = 11'h030;
        wdat[0][1] = 32'h55667788;
        sel[0][1]  = 4'hF;
        stb[0][1]  = 1'b1;
        tick();
        chk("ab_stb", s_stb[0], 1);
        tick();
        stb[0][1] = 1'b0;
        #1;
        chk("ab_noack", m1_ack[0], 0);
        tick();
        chk("ab_idle_stb", s_stb[0], 0);
        tick();
        chk("ab_no_retry", s_stb[0], 0);
        $display("abandoned write checked");
        xfer(0, 0, 1'b0, 11'h030, 32'h0, 4'hF, 32'h55667788);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
